mem_controller: RTL and testbench
=================================

# mem_controller

Memory controller sitting between the fetch/load-store units and the byte-wide unified RAM/IO bus. It is the responder for instruction-fetch requests from the instruction cache and for load/store requests from the load-store buffer. It serialises each request into 1–4 byte-wide RAM accesses and assembles or splits the 32-bit word. It returns a one-cycle valid pulse per completed request.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; low freezes the block.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write, 0 = read.
- io_buffer_full  in  1  UART buffer full; stalls IO writes.
- inst_enable  in  1  fetch request, held until inst_valid.
- inst_addr  in  32  fetch address, word-aligned.
- inst  out  32  fetched instruction, little-endian.
- inst_valid  out  1  one-cycle completion pulse.
- data_enable  in  1  load/store request, held until data_valid.
- data_wr  in  1  1 = store, 0 = load.
- data_addr  in  32  byte address.
- data_len  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- data_in  in  32  store data, low bytes used.
- data_out  out  32  load data, zero-extended.
- data_valid  out  1  one-cycle completion pulse.
- rollback  in  1  misprediction flush.

## Operation
- States:
  - IDLE.
  - RUN: byte transfers for the accepted op.
  - DONE: valid pulse.
- IDLE:
  - Sample requests each edge. data_enable has priority over inst_enable.
  - Latch the op type, address, byte count n (1, 2 or 4), and store data.
- RUN read:
  - Byte i is requested at address base+i.
  - It lands in bits [8i+7:8i] of the result. Unused upper bits are 0.
- RUN write:
  - Drive mem_a = base+i, mem_dout = store byte i, and mem_wr = 1 for one cycle per byte.
- IO write: address with bits [17:16] = 2'b11 while io_buffer_full = 1.
  - Hold in RUN with mem_wr = 0, mem_a = 0, and no progress until io_buffer_full = 0.
- DONE:
  - Assert inst_valid or data_valid for exactly one cycle, with inst or data_out stable.
  - Then return to IDLE without sampling requests that edge. This prevents re-accepting a request whose enable drops on the valid edge.
- rollback = 1 (sampled on an edge):
  - An in-flight fetch or load returns to IDLE with no valid pulse, mem_wr = 0, mem_a = 0.
  - An in-flight store always completes.
  - In IDLE, rollback suppresses acceptance that edge.
  - In DONE, the pulse still occurs.
- rdy = 0:
  - No state, counter, or output register changes.
  - mem_wr forced 0.
  - A paused RAM read byte is re-requested when rdy returns.
- Idle bus values: mem_a = 0, mem_wr = 0.
- Reset values (asynchronous): all outputs 0, state IDLE, counters 0.

## Timing
- Request sampled at edge E0.
- Byte i address is driven after E(i).
- For reads, mem_din for that address is captured at E(i+1).
- For writes, byte i is committed at E(i+1).
- After E(n), the state is DONE and the valid signal is high for one cycle. Valid is therefore visible n cycles after acceptance.
  - Word fetch: valid after E4.
  - Byte load: valid after E1.
- After the valid cycle, the earliest next acceptance is the edge two after E(n).
- Each IO-full stall cycle adds one cycle.
- Address increments are 32-bit modulo, so 0xFFFFFFFF wraps to 0x00000000.

## Test plan
- Word fetch:
  - Stimulus: inst_addr = 0x1000, RAM[0x1000..0x1003] = 13 05 00 00.
  - Response: mem_a steps 0x1000–0x1003, mem_wr = 0, inst = 0x00000513 with inst_valid high for one cycle, 4 cycles after acceptance; no second fetch while enable stays high on the valid edge.
- Simultaneous requests:
  - Stimulus: inst_enable and data_enable (load word at 0x20) asserted on the same edge.
  - Response: the load is served first with data_valid; the fetch is then accepted and its inst_valid follows.
- Halfword store:
  - Stimulus: data_addr = 0x21, data_in = 0x1234BEEF, data_len = 1.
  - Response: mem_wr = 1 for two cycles with (0x21, 0xEF) then (0x22, 0xBE); data_valid after 2 cycles; RAM[0x23] untouched.
- IO stall:
  - Stimulus: byte store to 0x30000 with io_buffer_full = 1 for 3 cycles.
  - Response: mem_wr stays 0 during the stall; one write of the byte once full drops; data_valid after 4 cycles.
- Rollback:
  - Stimulus: rollback pulsed after the second byte of a word fetch.
  - Response: no inst_valid, state returns to IDLE, mem_a = 0.
  - Stimulus: the same rollback mid-store.
  - Response: all bytes are written and data_valid pulses.
- Reset/rdy:
  - Stimulus: rst asserted mid-word-store.
  - Response: outputs go 0 immediately, asynchronously.
  - Stimulus: rdy low for 2 cycles mid-load.
  - Response: same data_out as an unstalled load, with latency increased by 2.

Source files
------------

// File: rtl/mem_controller.sv
// Byte-serial memory controller: turns fetch and load/store requests into 1-4 byte-wide
// RAM/IO bus accesses, packs the read bytes into a 32-bit word (or splits the store word
// into bytes), and pulses a one-cycle valid when each request completes.
module mem_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        inst_enable,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        data_enable,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_len,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        rollback
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic        is_data_q, is_data_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] base_q, base_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] data_out_q, data_out_d;
  logic        inst_valid_q, inst_valid_d;
  logic        data_valid_q, data_valid_d;

  logic        running;
  logic [31:0] cur_addr;
  logic        io_stall;
  logic [7:0]  wbyte;
  logic [31:0] rbuf_next;

  // Bus side: address/data of the current byte; IO writes park the bus while UART is full
  always_comb begin
    running  = (state_q == StRun);
    cur_addr = base_q + {30'b0, cnt_q};
    io_stall = running && is_wr_q && (cur_addr[17:16] == 2'b11) && io_buffer_full;
    unique case (cnt_q)
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
    rbuf_next = rbuf_q | ({24'b0, mem_din} << {cnt_q, 3'b000});
    mem_a     = (running && !io_stall) ? cur_addr : 32'b0;
    mem_dout  = (running && is_wr_q && !io_stall) ? wbyte : 8'b0;
    mem_wr    = running && is_wr_q && !io_stall && rdy;
  end

  // Next-state: accept in idle, step bytes in run, single valid cycle in done
  always_comb begin
    state_d      = state_q;
    is_data_d    = is_data_q;
    is_wr_d      = is_wr_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    inst_d       = inst_q;
    data_out_d   = data_out_q;
    inst_valid_d = inst_valid_q;
    data_valid_d = data_valid_q;
    if (rdy) begin
      unique case (state_q)
        StIdle: begin
          if (!rollback && (data_enable || inst_enable)) begin
            state_d = StRun;
            cnt_d   = 2'd0;
            rbuf_d  = 32'b0;
            if (data_enable) begin
              is_data_d = 1'b1;
              is_wr_d   = data_wr;
              base_d    = data_addr;
              // last byte index; the illegal length 3 is treated as a word
              last_d    = data_len[1] ? 2'd3 : {1'b0, data_len[0]};
              wdata_d   = data_in;
            end else begin
              is_data_d = 1'b0;
              is_wr_d   = 1'b0;
              base_d    = inst_addr;
              last_d    = 2'd3;
            end
          end
        end
        StRun: begin
          if (rollback && !is_wr_q) begin
            state_d = StIdle;
            cnt_d   = 2'd0;
          end else if (!io_stall) begin
            if (!is_wr_q) rbuf_d = rbuf_next;
            if (cnt_q == last_q) begin
              state_d = StDone;
              cnt_d   = 2'd0;
              if (is_data_q) begin
                data_valid_d = 1'b1;
                if (!is_wr_q) data_out_d = rbuf_next;
              end else begin
                inst_valid_d = 1'b1;
                inst_d       = rbuf_next;
              end
            end else begin
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
        StDone: begin
          // requests are deliberately not sampled here
          state_d      = StIdle;
          inst_valid_d = 1'b0;
          data_valid_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      is_data_q    <= 1'b0;
      is_wr_q      <= 1'b0;
      base_q       <= 32'b0;
      cnt_q        <= 2'd0;
      last_q       <= 2'd0;
      wdata_q      <= 32'b0;
      rbuf_q       <= 32'b0;
      inst_q       <= 32'b0;
      data_out_q   <= 32'b0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_data_q    <= is_data_d;
      is_wr_q      <= is_wr_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      wdata_q      <= wdata_d;
      rbuf_q       <= rbuf_d;
      inst_q       <= inst_d;
      data_out_q   <= data_out_d;
      inst_valid_q <= inst_valid_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: a byte RAM with asynchronous read, a transaction-level
// reference memory, directed scenarios and randomized fetch/load/store traffic.
module tb_mem_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        inst_enable;
  logic [31:0] inst_addr;
  logic [31:0] inst;
  logic        inst_valid;
  logic        data_enable;
  logic        data_wr;
  logic [31:0] data_addr;
  logic [1:0]  data_len;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        data_valid;
  logic        rollback;

  int total = 0;
  int bad   = 0;

  logic [7:0] ram     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] io_log  [$];

  mem_controller dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .inst_enable(inst_enable),
    .inst_addr(inst_addr), .inst(inst), .inst_valid(inst_valid), .data_enable(data_enable),
    .data_wr(data_wr), .data_addr(data_addr), .data_len(data_len), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .rollback(rollback)
  );

  always #5 clk = ~clk;

  assign mem_din = ram[mem_a[15:0]];

  // Bus-side RAM / IO sink
  always @(posedge clk) begin
    if (mem_wr === 1'b1) begin
      if (mem_a[17:16] == 2'b11) io_log.push_back(mem_dout);
      else ram[mem_a[15:0]] <= mem_dout;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic int len_bytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  // One request from issue to idle; checks bus activity cycle by cycle and valid latency.
  // rs/rk: rdy low for rk cycles starting rs cycles after acceptance; io_st: IO-full cycles;
  // rb: cycle in which rollback is pulsed (-1 for none).
  task automatic xact(input bit is_d, input bit wr, input logic [31:0] addr,
                      input logic [1:0] len, input logic [31:0] wd, input int rs, input int rk,
                      input int io_st, input int rb, output logic [31:0] res);
    int n, p, cyc;
    bit got, stall_io;
    logic [31:0] wbyte;
    n = len_bytes(len);
    p = 0; cyc = 0; got = 0; res = 32'b0;
    if (is_d) begin
      data_enable = 1'b1; data_wr = wr; data_addr = addr; data_len = len; data_in = wd;
    end else begin
      inst_enable = 1'b1; inst_addr = addr;
    end
    @(posedge clk); #1;
    while (!got && cyc < 64) begin
      rdy            = !(cyc >= rs && cyc < rs + rk);
      io_buffer_full = (cyc < io_st);
      rollback       = (cyc == rb);
      stall_io       = wr && (cyc < io_st);
      #1;
      if (is_d ? data_valid : inst_valid) begin
        got = 1;
        check_eq("latency", cyc, n + rk + io_st);
        res = is_d ? data_out : inst;
      end else begin
        if (p < n) begin
          check_eq("mem_a", mem_a, stall_io ? 32'b0 : addr + p);
          check_eq("mem_wr", {31'b0, mem_wr}, {31'b0, wr && rdy && !stall_io});
          if (wr && !stall_io) begin
            wbyte = (wd >> (8 * p)) & 32'hFF;
            check_eq("mem_dout", {24'b0, mem_dout}, wbyte);
          end
        end
        if (rdy && !stall_io) p++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    rdy = 1'b1; io_buffer_full = 1'b0; rollback = 1'b0;
    if (!got) check_eq("valid_timeout", 32'd0, 32'd1);
    // enable stays high through the valid edge; must not be re-accepted
    @(posedge clk); #1;
    if (is_d) data_enable = 1'b0; else inst_enable = 1'b0;
    #1;
    check_eq("valid_once", {31'b0, is_d ? data_valid : inst_valid}, 32'd0);
    check_eq("idle_mem_a", mem_a, 32'b0);
  endtask

  // Request plus reference-model bookkeeping
  task automatic op(input bit is_d, input bit wr, input logic [31:0] addr,
                    input logic [1:0] len, input logic [31:0] wd, input int rs, input int rk);
    int n;
    logic [31:0] exp, res, a;
    n = len_bytes(len);
    exp = 32'b0;
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      exp = exp | ({24'b0, ref_mem[a[15:0]]} << (8 * i));
    end
    xact(is_d, wr, addr, len, wd, rs, rk, 0, -1, res);
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        a = addr + i;
        ref_mem[a[15:0]] = 8'((wd >> (8 * i)) & 32'hFF);
      end
    end else begin
      check_eq(is_d ? "data_out" : "inst", res, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] v);
    ram[a] = v;
    ref_mem[a] = v;
  endtask

  initial begin
    logic [31:0] res, v;
    int kind, rk, rs, nb, cnt;
    logic [1:0] len;
    logic [31:0] addr;

    for (int i = 0; i < 65536; i++) begin
      v = $urandom;
      ram[i] = v[7:0];
      ref_mem[i] = v[7:0];
    end
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0; inst_enable = 1'b0; inst_addr = 32'b0;
    data_enable = 1'b0; data_wr = 1'b0; data_addr = 32'b0; data_len = 2'd0;
    data_in = 32'b0; rollback = 1'b0;
    #12;
    check_eq("rst_mem_a", mem_a, 32'b0);
    check_eq("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    check_eq("rst_outs", inst | data_out | {24'b0, mem_dout}, 32'b0);
    check_eq("rst_valids", {30'b0, inst_valid, data_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Word fetch
    poke(16'h1000, 8'h13); poke(16'h1001, 8'h05); poke(16'h1002, 8'h00); poke(16'h1003, 8'h00);
    xact(0, 0, 32'h1000, 2'd2, 32'b0, 0, 0, 0, -1, res);
    check_eq("fetch_word", res, 32'h0000_0513);

    // Simultaneous requests: load served first, fetch after
    poke(16'h0020, 8'hDE); poke(16'h0021, 8'hAD); poke(16'h0022, 8'hC0); poke(16'h0023, 8'hDE);
    inst_enable = 1'b1; inst_addr = 32'h1000;
    xact(1, 0, 32'h20, 2'd2, 32'b0, 0, 0, 0, -1, res);
    check_eq("simul_load", res, 32'hDEC0_ADDE);
    xact(0, 0, 32'h1000, 2'd2, 32'b0, 0, 0, 0, -1, res);
    check_eq("simul_fetch", res, 32'h0000_0513);

    // Halfword store at an odd address; following byte untouched
    poke(16'h0023, 8'h77);
    op(1, 1, 32'h21, 2'd1, 32'h1234_BEEF, 0, 0);
    @(posedge clk); #1;
    check_eq("hw_lo", {24'b0, ram[16'h21]}, 32'hEF);
    check_eq("hw_hi", {24'b0, ram[16'h22]}, 32'hBE);
    check_eq("hw_keep", {24'b0, ram[16'h23]}, 32'h77);

    // IO store stalled by a full UART buffer
    xact(1, 1, 32'h0003_0000, 2'd0, 32'h0000_00A5, 0, 0, 3, -1, res);
    @(posedge clk); #1;
    check_eq("io_count", io_log.size(), 1);
    if (io_log.size() > 0) check_eq("io_byte", {24'b0, io_log[0]}, 32'hA5);

    // Rollback after the second fetched byte: abandoned, no pulse
    inst_enable = 1'b1; inst_addr = 32'h1000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rollback = 1'b1; inst_enable = 1'b0;
    @(posedge clk); #1;
    rollback = 1'b0;
    check_eq("rb_mem_a", mem_a, 32'b0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (inst_valid) cnt++;
      @(posedge clk); #1;
    end
    check_eq("rb_no_valid", cnt, 0);

    // Rollback mid-store: store completes
    xact(1, 1, 32'h50, 2'd2, 32'hCAFE_F00D, 0, 0, 0, 2, res);
    for (int i = 0; i < 4; i++) ref_mem[16'h50 + i] = 8'((32'hCAFE_F00D >> (8 * i)) & 32'hFF);

    // rdy low for two cycles mid-load
    op(1, 0, 32'h50, 2'd2, 32'b0, 1, 2);

    // Asynchronous reset during a word store
    data_enable = 1'b1; data_wr = 1'b1; data_addr = 32'h40; data_len = 2'd2;
    data_in = 32'h8877_6655;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_mem_wr", {31'b0, mem_wr}, 32'd0);
    check_eq("arst_mem_a", mem_a, 32'b0);
    check_eq("arst_outs", inst | data_out | {24'b0, mem_dout}, 32'b0);
    data_enable = 1'b0; data_wr = 1'b0;
    ref_mem[16'h40] = 8'h55;
    @(posedge clk); #1 rst = 1'b0;

    // Address wrap across 0xFFFFFFFF
    op(1, 0, 32'hFFFF_FFFE, 2'd2, 32'b0, 0, 0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      len  = 2'($urandom_range(0, 2));
      addr = 32'h100 + $urandom_range(0, 63);
      nb   = (kind == 0) ? 4 : len_bytes(len);
      rs   = $urandom_range(0, nb - 1);
      rk   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      if (kind == 0) op(0, 0, addr & 32'hFFFF_FFFC, 2'd2, 32'b0, rs, rk);
      else op(1, kind == 2, addr, len, $urandom, rs, rk);
    end

    // RAM as written by the DUT must match the reference memory
    @(posedge clk); #1;
    cnt = 0;
    for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) cnt++;
    check_eq("ram_scan", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
